alu_cmd_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the ALU, i.e. upstream of the ALU function decoder.
- Assembles ALU commands from UART RX bytes and drives operands, ALU_FUN and ALU_EN.
- Captures the ALU result and returns it LSB-first over the UART TX byte interface.
- Sits between uart_rx/uart_tx and the ALU in the UART system top.

---
 rtl/alu_sys_pkg.sv | 40 ++++
 rtl/alu_res_tx_ser.sv | 94 +++++++++
 rtl/alu_cmd_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sys_pkg.sv
// Shared definitions for the UART-driven ALU system: command opcodes,
// FSM state encoding and ALU function class codes.
package alu_sys_pkg;

    localparam int ALU_DW = 8;

    localparam logic [7:0] OPC_ALU_OPER = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP  = 8'hDD;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_GET_A    = 4'd1;
    localparam logic [3:0] ST_GET_B    = 4'd2;
    localparam logic [3:0] ST_GET_FUN  = 4'd3;
    localparam logic [3:0] ST_ALU_RUN  = 4'd4;
    localparam logic [3:0] ST_WAIT_RES = 4'd5;
    localparam logic [3:0] ST_SEND_LO  = 4'd6;
    localparam logic [3:0] ST_WAIT_LO  = 4'd7;
    localparam logic [3:0] ST_SEND_HI  = 4'd8;
    localparam logic [3:0] ST_WAIT_HI  = 4'd9;

    typedef enum logic [3:0] {
        IDLE     = ST_IDLE,
        GET_A    = ST_GET_A,
        GET_B    = ST_GET_B,
        GET_FUN  = ST_GET_FUN,
        ALU_RUN  = ST_ALU_RUN,
        WAIT_RES = ST_WAIT_RES,
        SEND_LO  = ST_SEND_LO,
        WAIT_LO  = ST_WAIT_LO,
        SEND_HI  = ST_SEND_HI,
        WAIT_HI  = ST_WAIT_HI
    } state_t;

    // ALU_FUN[3:2] selects the function class in the ALU decoder.
    localparam logic [1:0] FUN_ARITH = 2'b00;
    localparam logic [1:0] FUN_LOGIC = 2'b01;
    localparam logic [1:0] FUN_CMP   = 2'b10;
    localparam logic [1:0] FUN_SHIFT = 2'b11;

endpackage

// File: rtl/alu_res_tx_ser.sv
// Result latch and two-byte TX serializer (low byte first).
// Ports: start/result from the command FSM, tx_busy from uart_tx,
// tx_data/tx_vld to uart_tx, done strobe back to the command FSM.
module alu_res_tx_ser
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] result,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_vld,
    output logic                    done
);

    state_t                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    // Set once uart_tx has raised busy for the byte just handed over.
    logic                    seen_q, seen_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            res_q     <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            seen_q    <= seen_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
        seen_d    = seen_q;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    res_d   = result;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (!tx_busy) begin
                    tx_data_d = res_q[DATA_WIDTH-1:0];
                    tx_vld_d  = 1'b1;
                    seen_d    = 1'b0;
                    state_d   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!seen_q) begin
                    seen_d = tx_busy;
                end else if (!tx_busy) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!tx_busy) begin
                    tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_vld_d  = 1'b1;
                    seen_d    = 1'b0;
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (!seen_q) begin
                    seen_d = tx_busy;
                end else if (!tx_busy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_data = tx_data_q;
    assign tx_vld  = tx_vld_q;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer ahead of the ALU: builds commands from UART RX
// bytes, drives ALU_A/ALU_B/ALU_FUN/ALU_EN and returns the result
// over UART TX. Ports: CLK/RST, RX byte strobe, ALU result strobe,
// TX busy in; operands, function, start, TX byte and drop strobe out.
module alu_cmd_ctrl
    import alu_sys_pkg::*;
#(
    parameter int                    DATA_WIDTH   = ALU_DW,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER = DATA_WIDTH'(OPC_ALU_OPER),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP  = DATA_WIDTH'(OPC_ALU_NOP)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    TX_BUSY,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [3:0]              ALU_FUN,
    output logic                    ALU_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    CMD_DROP
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [3:0]            fun_q, fun_d;
    logic                  en_q, en_d;
    logic                  drop_q, drop_d;
    logic                  ser_start;
    logic                  ser_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            en_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            en_q    <= en_d;
            drop_q  <= drop_d;
        end
    end

    // While the serializer owns the result, this FSM parks in SEND_LO
    // until done; the per-byte SEND/WAIT sequencing lives in the
    // serializer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        en_d      = 1'b0;
        drop_d    = 1'b0;
        ser_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_ALU_OPER) begin
                        state_d = GET_A;
                    end else if (RX_P_DATA == CMD_ALU_NOP) begin
                        state_d = GET_FUN;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    a_d     = RX_P_DATA;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    b_d     = RX_P_DATA;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[3:0];
                    state_d = ALU_RUN;
                end
            end
            ALU_RUN: begin
                en_d    = 1'b1;
                drop_d  = RX_D_VLD;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                drop_d = RX_D_VLD;
                if (OUT_VALID) begin
                    ser_start = 1'b1;
                    state_d   = SEND_LO;
                end
            end
            SEND_LO: begin
                drop_d = RX_D_VLD;
                if (ser_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                drop_d  = RX_D_VLD;
                state_d = IDLE;
            end
        endcase
    end

    alu_res_tx_ser #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk     (CLK),
        .rst_n   (RST),
        .start   (ser_start),
        .result  (ALU_OUT),
        .tx_busy (TX_BUSY),
        .tx_data (TX_P_DATA),
        .tx_vld  (TX_D_VLD),
        .done    (ser_done)
    );

    assign ALU_A    = a_q;
    assign ALU_B    = b_q;
    assign ALU_FUN  = fun_q;
    assign ALU_EN   = en_q;
    assign CMD_DROP = drop_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl with behavioural ALU and
// uart_tx stand-ins and a command-level reference model.
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_VALID = 1'b0;
    logic        force_busy = 1'b0;
    logic        model_busy = 1'b0;
    wire         TX_BUSY = force_busy | model_busy;
    logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, TX_D_VLD, CMD_DROP;

    alu_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .TX_BUSY(TX_BUSY),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .ALU_EN(ALU_EN), .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD), .CMD_DROP(CMD_DROP)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus knobs
    logic [15:0] alu_val = '0;
    int alu_lat = 1;
    int tx_len = 4;

    // reference model of the operand registers
    logic [7:0] m_a = '0, m_b = '0;
    logic [3:0] m_f = '0;

    // observation log
    int cyc = 0;
    int en_cnt = 0;
    int drop_cnt = 0;
    int busy_viol = 0;
    logic [7:0] en_a, en_b;
    logic [3:0] en_f;
    logic [7:0] tx_q[$];
    int tx_cyc[$];
    int tx_rd = 0;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (ALU_EN) begin
            en_cnt = en_cnt + 1;
            en_a = ALU_A;
            en_b = ALU_B;
            en_f = ALU_FUN;
        end
        if (TX_D_VLD) begin
            tx_q.push_back(TX_P_DATA);
            tx_cyc.push_back(cyc);
            if (TX_BUSY) busy_viol = busy_viol + 1;
        end
        if (CMD_DROP) drop_cnt = drop_cnt + 1;
    end

    // ALU stand-in: answers ALU_EN after alu_lat cycles
    always begin
        @(negedge CLK);
        if (ALU_EN) begin
            repeat (alu_lat) @(posedge CLK);
            #1;
            ALU_OUT = alu_val;
            OUT_VALID = 1'b1;
            @(posedge CLK);
            #1;
            OUT_VALID = 1'b0;
        end
    end

    // uart_tx stand-in: busy for tx_len cycles per byte
    always begin
        @(negedge CLK);
        if (TX_D_VLD) begin
            @(posedge CLK);
            #1;
            model_busy = 1'b1;
            repeat (tx_len) @(posedge CLK);
            #1;
            model_busy = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_P_DATA = b;
        RX_D_VLD = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_en(output bit ok);
        int s;
        s = en_cnt;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge CLK);
            #1;
            if (en_cnt != s) ok = 1'b1;
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            #1;
            if (tx_q.size() >= tx_rd + n) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        idle_cycles(3);
        @(negedge CLK);
        n_cmp++;
        if ({ALU_A, ALU_B, ALU_FUN} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_ops: got %h/%h/%h want 0", ALU_A, ALU_B, ALU_FUN);
        end
        n_cmp++;
        if ({ALU_EN, TX_D_VLD, CMD_DROP} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b want 000", {ALU_EN, TX_D_VLD, CMD_DROP});
        end
        n_cmp++;
        if (TX_P_DATA !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_txdata: got %h want 00", TX_P_DATA);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        m_a = '0;
        m_b = '0;
        m_f = '0;
        idle_cycles(2);
    endtask

    task automatic test_oper;
        bit ok;
        int e0;
        e0 = en_cnt;
        alu_val = 16'h0008;
        alu_lat = 1;
        send_byte(8'hCC);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h00);
        m_a = 8'h05;
        m_b = 8'h03;
        m_f = 4'h0;
        wait_en(ok);
        n_cmp++;
        if (!ok || en_a !== m_a || en_b !== m_b || en_f !== m_f) begin
            n_bad++;
            $display("FAIL oper_operands: ok=%0d got %h/%h/%h want %h/%h/%h", ok, en_a, en_b, en_f, m_a, m_b, m_f);
        end
        wait_tx(2, ok);
        n_cmp++;
        if (!ok || tx_q[tx_rd] !== 8'h08 || tx_q[tx_rd+1] !== 8'h00) begin
            n_bad++;
            $display("FAIL oper_tx: ok=%0d want 08,00", ok);
        end
        tx_rd = tx_q.size();
        idle_cycles(tx_len + 6);
        n_cmp++;
        if (en_cnt - e0 !== 1) begin
            n_bad++;
            $display("FAIL oper_en_pulses: got %0d want 1", en_cnt - e0);
        end
    endtask

    task automatic test_nop;
        bit ok;
        alu_val = 16'h1234;
        send_byte(8'hDD);
        send_byte(8'h01);
        m_f = 4'h1;
        wait_en(ok);
        n_cmp++;
        if (!ok || en_a !== m_a || en_b !== m_b || en_f !== m_f) begin
            n_bad++;
            $display("FAIL nop_operands: ok=%0d got %h/%h/%h want %h/%h/%h", ok, en_a, en_b, en_f, m_a, m_b, m_f);
        end
        wait_tx(2, ok);
        n_cmp++;
        if (!ok || tx_q[tx_rd] !== 8'h34 || tx_q[tx_rd+1] !== 8'h12) begin
            n_bad++;
            $display("FAIL nop_tx: ok=%0d want 34,12", ok);
        end
        tx_rd = tx_q.size();
        idle_cycles(tx_len + 6);
    endtask

    task automatic test_drop_idle;
        int d0, e0;
        d0 = drop_cnt;
        e0 = en_cnt;
        send_byte(8'h7F);
        idle_cycles(6);
        n_cmp++;
        if (drop_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL drop_idle_pulse: got %0d want 1", drop_cnt - d0);
        end
        n_cmp++;
        if (en_cnt != e0 || ALU_A !== m_a || tx_q.size() != tx_rd) begin
            n_bad++;
            $display("FAIL drop_idle_side: en=%0d a=%h want en=0 a=%h", en_cnt - e0, ALU_A, m_a);
        end
    endtask

    task automatic test_drop_wait_res;
        bit ok;
        int d0;
        alu_lat = 6;
        alu_val = 16'hA55A;
        send_byte(8'hCC);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'hF3);
        m_a = 8'h11;
        m_b = 8'h22;
        m_f = 4'h3;
        wait_en(ok);
        d0 = drop_cnt;
        send_byte(8'h55);
        wait_tx(2, ok);
        n_cmp++;
        if (drop_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL drop_waitres_pulse: got %0d want 1", drop_cnt - d0);
        end
        n_cmp++;
        if (!ok || tx_q[tx_rd] !== 8'h5A || tx_q[tx_rd+1] !== 8'hA5) begin
            n_bad++;
            $display("FAIL drop_waitres_tx: ok=%0d want 5A,A5", ok);
        end
        n_cmp++;
        if (en_f !== m_f || en_a !== m_a) begin
            n_bad++;
            $display("FAIL drop_waitres_fun: got %h/%h want %h/%h", en_a, en_f, m_a, m_f);
        end
        tx_rd = tx_q.size();
        alu_lat = 1;
        idle_cycles(tx_len + 6);
    endtask

    task automatic test_busy_hold;
        bit ok;
        int t0, gap;
        bit early;
        alu_val = 16'hBEEF;
        @(posedge CLK);
        #1;
        force_busy = 1'b1;
        send_byte(8'hDD);
        send_byte(8'h07);
        m_f = 4'h7;
        wait_en(ok);
        early = 1'b0;
        t0 = tx_q.size();
        repeat (24) begin
            @(negedge CLK);
            if (TX_D_VLD) early = 1'b1;
        end
        n_cmp++;
        if (early || tx_q.size() != t0) begin
            n_bad++;
            $display("FAIL busy_hold: TX_D_VLD rose while busy, want 0");
        end
        @(posedge CLK);
        #1;
        force_busy = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (TX_D_VLD !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_release_early: got %b want 0", TX_D_VLD);
        end
        @(negedge CLK);
        n_cmp++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'hEF) begin
            n_bad++;
            $display("FAIL busy_release_lo: got %b/%h want 1/EF", TX_D_VLD, TX_P_DATA);
        end
        wait_tx(2, ok);
        gap = ok ? tx_cyc[tx_rd+1] - tx_cyc[tx_rd] : 0;
        n_cmp++;
        if (!ok || tx_q[tx_rd+1] !== 8'hBE || gap <= tx_len || gap > tx_len + 4) begin
            n_bad++;
            $display("FAIL busy_hi_byte: ok=%0d gap=%0d want BE with gap in (%0d,%0d]", ok, gap, tx_len, tx_len + 4);
        end
        tx_rd = tx_q.size();
        idle_cycles(tx_len + 6);
    endtask

    task automatic test_reset_mid;
        bit ok;
        send_byte(8'hCC);
        send_byte(8'h05);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        n_cmp++;
        if ({ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D_VLD, CMD_DROP} !== 23'h0 || TX_P_DATA !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h/%h/%h/%b%b%b want all 0", ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D_VLD, CMD_DROP);
        end
        m_a = '0;
        m_b = '0;
        m_f = '0;
        idle_cycles(2);
        RST = 1'b1;
        idle_cycles(2);
        alu_val = 16'h00C3;
        send_byte(8'hDD);
        send_byte(8'h02);
        m_f = 4'h2;
        wait_en(ok);
        n_cmp++;
        if (!ok || en_a !== m_a || en_b !== m_b || en_f !== m_f) begin
            n_bad++;
            $display("FAIL reset_mid_nop: ok=%0d got %h/%h/%h want %h/%h/%h", ok, en_a, en_b, en_f, m_a, m_b, m_f);
        end
        wait_tx(2, ok);
        n_cmp++;
        if (!ok || tx_q[tx_rd] !== 8'hC3 || tx_q[tx_rd+1] !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_tx: ok=%0d want C3,00", ok);
        end
        tx_rd = tx_q.size();
        idle_cycles(tx_len + 6);
    endtask

    task automatic test_random;
        bit ok;
        int kind, d0, e0;
        logic [7:0] a, b, f, junk;
        logic [15:0] r;
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 2);
            tx_len = $urandom_range(2, 6);
            alu_lat = $urandom_range(1, 4);
            a = ($urandom_range(0, 3) == 0) ? 8'hCC : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'hDD : 8'($urandom);
            f = 8'($urandom);
            r = 16'($urandom);
            alu_val = r;
            d0 = drop_cnt;
            e0 = en_cnt;
            if (kind == 2) begin
                junk = 8'($urandom);
                if (junk == 8'hCC || junk == 8'hDD) junk = 8'h00;
                send_byte(junk);
                idle_cycles(5);
                n_cmp++;
                if (drop_cnt - d0 !== 1 || en_cnt != e0) begin
                    n_bad++;
                    $display("FAIL rand_junk[%0d]: drops=%0d ens=%0d want 1/0", it, drop_cnt - d0, en_cnt - e0);
                end
            end else begin
                if (kind == 0) begin
                    send_byte(8'hCC);
                    send_byte(a);
                    send_byte(b);
                    m_a = a;
                    m_b = b;
                end else begin
                    send_byte(8'hDD);
                end
                send_byte(f);
                m_f = f[3:0];
                wait_en(ok);
                n_cmp++;
                if (!ok || en_a !== m_a || en_b !== m_b || en_f !== m_f) begin
                    n_bad++;
                    $display("FAIL rand_ops[%0d]: got %h/%h/%h want %h/%h/%h", it, en_a, en_b, en_f, m_a, m_b, m_f);
                end
                wait_tx(2, ok);
                n_cmp++;
                if (!ok || {tx_q[tx_rd+1], tx_q[tx_rd]} !== r) begin
                    n_bad++;
                    $display("FAIL rand_tx[%0d]: ok=%0d want %h", it, ok, r);
                end
                tx_rd = tx_q.size();
                idle_cycles(tx_len + 6);
                n_cmp++;
                if (en_cnt - e0 !== 1 || drop_cnt != d0) begin
                    n_bad++;
                    $display("FAIL rand_strobes[%0d]: ens=%0d drops=%0d want 1/0", it, en_cnt - e0, drop_cnt - d0);
                end
            end
        end
    endtask

    task automatic test_busy_rule;
        n_cmp++;
        if (busy_viol !== 0) begin
            n_bad++;
            $display("FAIL tx_vld_while_busy: got %0d want 0", busy_viol);
        end
    endtask

    initial begin
        test_reset;
        test_oper;
        test_nop;
        test_drop_idle;
        test_drop_wait_res;
        test_busy_hold;
        test_reset_mid;
        test_random;
        test_busy_rule;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
